// File: rtl/axis_stream_checker.sv
// AXI4-Stream sink checking a +1 counter payload, TLAST spacing and full TKEEP; one-cycle bus reads.
// Beat effects visible one cycle after handshake; TREADY follows READY_MASK[phase], never tvalid.
module axis_stream_checker #(
  parameter logic [31:0] PKT_SIZE_RST   = 32'd256,
  parameter logic [7:0]  READY_MASK_RST = 8'hFF
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [7:0]  s_axis_tkeep,
  input  logic [31:0] sys_addr_i,
  input  logic [31:0] sys_wdata_i,
  input  logic [3:0]  sys_sel_i,
  input  logic        sys_wen_i,
  input  logic        sys_ren_i,
  output logic [31:0] sys_rdata_o,
  output logic        sys_err_o,
  output logic        sys_ack_o,
  output logic        err_o
);

  localparam logic [19:0] A_CTRL   = 20'h00;
  localparam logic [19:0] A_STATUS = 20'h04;
  localparam logic [19:0] A_PKT    = 20'h08;
  localparam logic [19:0] A_MASK   = 20'h0C;
  localparam logic [19:0] A_WORD   = 20'h10;
  localparam logic [19:0] A_PKTCNT = 20'h14;
  localparam logic [19:0] A_ERRCNT = 20'h18;
  localparam logic [19:0] A_LO     = 20'h1C;
  localparam logic [19:0] A_HI     = 20'h20;

  typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_RUN} state_t;

  state_t      state, state_nxt;
  logic [19:0] addr;
  logic        unused_bits;
  logic        ctrl_enable, ctrl_dchk, clear_pulse;
  logic [31:0] pkt_size, ps_eff, ps_act, pos;
  logic [7:0]  ready_mask;
  logic [2:0]  phase;
  logic [63:0] expected, last_data;
  logic [31:0] word_cnt, pkt_cnt, err_cnt, last_hi, rd_mux;
  logic        locked, data_err, last_err, keep_err;
  logic        beat, last_hit, data_err_b, last_err_b, keep_err_b;

  assign addr        = sys_addr_i[19:0];
  assign unused_bits = ^{sys_sel_i, sys_addr_i[31:20]};
  assign sys_err_o   = 1'b0;

  wire wr_ctrl = sys_wen_i && (addr == A_CTRL);
  wire wr_pkt  = sys_wen_i && (addr == A_PKT);
  wire wr_mask = sys_wen_i && (addr == A_MASK);

  assign ps_eff        = (pkt_size < 32'd2) ? 32'd2 : pkt_size;
  assign s_axis_tready = ctrl_enable & ~clear_pulse & ready_mask[phase];
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign last_hit      = (pos == ps_act - 32'd1);
  assign data_err_b    = beat && (state == ST_RUN) && ctrl_dchk && (s_axis_tdata != expected);
  assign last_err_b    = beat && (s_axis_tlast != last_hit);
  assign keep_err_b    = beat && (s_axis_tkeep != 8'hFF);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      ctrl_enable <= 1'b0;
      ctrl_dchk   <= 1'b0;
      clear_pulse <= 1'b0;
      pkt_size    <= PKT_SIZE_RST;
      ready_mask  <= READY_MASK_RST;
    end else begin
      clear_pulse <= wr_ctrl & sys_wdata_i[0];
      if (wr_ctrl) {ctrl_dchk, ctrl_enable} <= sys_wdata_i[2:1];
      if (wr_pkt)  pkt_size <= sys_wdata_i;
      if (wr_mask) ready_mask <= sys_wdata_i[7:0];
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i || !ctrl_enable || clear_pulse) phase <= 3'd0;
    else                                          phase <= phase + 3'd1;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!ctrl_enable)     state_nxt = ST_IDLE;
    else if (clear_pulse) state_nxt = ST_HUNT;
    else begin
      case (state)
        ST_IDLE: state_nxt = beat ? ST_RUN : ST_HUNT;
        ST_HUNT: if (beat) state_nxt = ST_RUN;
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i || clear_pulse) begin
      word_cnt <= '0;
      pkt_cnt  <= '0;
      err_cnt  <= '0;
      locked   <= 1'b0;
      data_err <= 1'b0;
      last_err <= 1'b0;
      keep_err <= 1'b0;
      pos      <= '0;
      expected <= '0;
      if (sys_rst_i) ps_act <= 32'd2;
    end else begin
      // Packet length is latched only between packets
      if (pos == 32'd0) ps_act <= ps_eff;
      if (beat) begin
        word_cnt <= word_cnt + 32'd1;
        if (s_axis_tlast) pkt_cnt <= pkt_cnt + 32'd1;
        if ((data_err_b || last_err_b || keep_err_b) && (err_cnt != 32'hFFFF_FFFF))
          err_cnt <= err_cnt + 32'd1;
        expected <= s_axis_tdata + 64'd1;
        locked   <= 1'b1;
        data_err <= data_err | data_err_b;
        last_err <= last_err | last_err_b;
        keep_err <= keep_err | keep_err_b;
        pos      <= (s_axis_tlast || last_hit) ? 32'd0 : pos + 32'd1;
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      last_data <= '0;
      err_o     <= 1'b0;
    end else begin
      if (beat) last_data <= s_axis_tdata;
      err_o <= data_err | last_err | keep_err;
    end
  end

  always_comb begin
    rd_mux = 32'hFFFF_FFFF;
    case (addr)
      A_CTRL:   rd_mux = {29'd0, ctrl_dchk, ctrl_enable, 1'b0};
      A_STATUS: rd_mux = {28'd0, keep_err, last_err, data_err, locked};
      A_PKT:    rd_mux = pkt_size;
      A_MASK:   rd_mux = {24'd0, ready_mask};
      A_WORD:   rd_mux = word_cnt;
      A_PKTCNT: rd_mux = pkt_cnt;
      A_ERRCNT: rd_mux = err_cnt;
      A_LO:     rd_mux = last_data[31:0];
      A_HI:     rd_mux = last_hi;
      default:  rd_mux = 32'hFFFF_FFFF;
    endcase
  end

  // Upper half is frozen at the LAST_LO read so both halves come from one beat
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      sys_ack_o   <= 1'b0;
      sys_rdata_o <= '0;
      last_hi     <= '0;
    end else begin
      sys_ack_o <= sys_wen_i | sys_ren_i;
      if (sys_ren_i) begin
        sys_rdata_o <= rd_mux;
        if (addr == A_LO) last_hi <= last_data[63:32];
      end
    end
  end

endmodule

// File: tb/tb_axis_stream_checker.sv
// Randomized and directed bench for axis_stream_checker against a packet-level reference model.
module tb_axis_stream_checker;

  localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_PKT = 32'h08, A_MASK = 32'h0C;
  localparam logic [31:0] A_WORD = 32'h10, A_PKTCNT = 32'h14, A_ERRCNT = 32'h18;
  localparam logic [31:0] A_LO = 32'h1C, A_HI = 32'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tdata;
  logic        tvalid, tready, tlast;
  logic [7:0]  tkeep;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  sel;
  logic        wen, ren, sys_err, ack, err;

  always #5 clk = ~clk;

  axis_stream_checker #(.PKT_SIZE_RST(32'd256), .READY_MASK_RST(8'hFF)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tlast(tlast), .s_axis_tkeep(tkeep),
    .sys_addr_i(addr), .sys_wdata_i(wdata), .sys_sel_i(sel),
    .sys_wen_i(wen), .sys_ren_i(ren), .sys_rdata_o(rdata),
    .sys_err_o(sys_err), .sys_ack_o(ack), .err_o(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: packet index, expected next word, counters, sticky flags
  logic [31:0] cur_ps;
  bit          cur_dchk;
  logic [31:0] m_word, m_pkt, m_err, m_ps, m_idx;
  logic [63:0] m_exp;
  bit          m_run;
  logic [3:0]  m_st;

  task automatic model_clear();
    m_word = 0; m_pkt = 0; m_err = 0; m_idx = 0; m_exp = 0; m_run = 0; m_st = 0;
  endtask

  task automatic model_beat(input logic [63:0] d, input bit l, input logic [7:0] k);
    bit de, le, ke, endp;
    if (m_idx == 0) m_ps = (cur_ps < 2) ? 32'd2 : cur_ps;
    endp = (m_idx == m_ps - 1);
    de = m_run && cur_dchk && (d != m_exp);
    le = (l != endp);
    ke = (k != 8'hFF);
    m_idx = (l || endp) ? 32'd0 : m_idx + 1;
    m_exp = d + 64'd1;
    m_run = 1'b1;
    m_word = m_word + 1;
    if (l) m_pkt = m_pkt + 1;
    if ((de || le || ke) && m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
    m_st = m_st | {ke, le, de, 1'b1};
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
    if (a == A_CTRL) begin
      cur_dchk = d[2];
      if (d[0]) model_clear();
    end
    if (a == A_PKT) cur_ps = d;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; ren = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_beat(input logic [63:0] d, input bit l, input logic [7:0] k);
    bit acc;
    tvalid = 1'b1; tdata = d; tlast = l; tkeep = k;
    for (int w = 0; w < 64; w++) begin
      acc = tready;
      @(posedge clk); #1;
      if (acc) begin
        model_beat(d, l, k);
        return;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL beat_timeout: tready not seen for data %h within 64 cycles", d);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1; tvalid = 0; tdata = 0; tlast = 0; tkeep = 8'hFF;
    addr = 0; wdata = 0; sel = 4'hF; wen = 0; ren = 0;
    cur_ps = 256; cur_dchk = 0; m_ps = 2; model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", tready); end
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack); end
    n_checks++; if (err !== 1'b0 || sys_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b/%b want 0/0", err, sys_err); end
    bus_read(A_CTRL, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0", r); end
    bus_read(A_PKT, r);
    n_checks++; if (r !== 32'd256) begin n_fail++; $display("FAIL rst_pkt_size: got %h want 100", r); end
    bus_read(A_MASK, r);
    n_checks++; if (r !== 32'hFF) begin n_fail++; $display("FAIL rst_mask: got %h want ff", r); end
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL rst_status: got %h want 0", r); end
    bus_read(A_WORD, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL rst_word_cnt: got %h want 0", r); end
  endtask

  task automatic test_clean_stream();
    logic [31:0] r;
    bus_write(A_PKT, 256);
    bus_write(A_CTRL, 32'h6);
    for (int i = 0; i < 512; i++) drive_beat(64'(i), (i % 256) == 255, 8'hFF);
    idle(2);
    bus_read(A_WORD, r);
    n_checks++; if (r !== 32'd512) begin n_fail++; $display("FAIL t1_word_cnt: got %0d want 512", r); end
    bus_read(A_PKTCNT, r);
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL t1_pkt_cnt: got %0d want 2", r); end
    bus_read(A_ERRCNT, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL t1_err_cnt: got %0d want 0", r); end
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL t1_status: got %h want 1", r); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL t1_err_o: got %b want 0", err); end
  endtask

  task automatic test_data_error();
    logic [31:0] r;
    bus_write(A_CTRL, 32'h7);
    for (int i = 0; i < 512; i++) begin
      drive_beat((i < 100) ? 64'(i) : 64'(i + 5), (i % 256) == 255, 8'hFF);
      if (i == 100) begin
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL t2_err_o_early: got %b want 0", err); end
      end
      if (i == 101) begin
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL t2_err_o_late: got %b want 1", err); end
      end
    end
    idle(2);
    bus_read(A_ERRCNT, r);
    n_checks++; if (r !== 32'd1 || r !== m_err) begin n_fail++; $display("FAIL t2_err_cnt: got %0d want 1", r); end
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h3) begin n_fail++; $display("FAIL t2_status: got %h want 3", r); end
    bus_read(A_WORD, r);
    n_checks++; if (r !== 32'd512) begin n_fail++; $display("FAIL t2_word_cnt: got %0d want 512", r); end
  endtask

  task automatic test_last_error();
    logic [31:0] r;
    bus_write(A_PKT, 16);
    bus_write(A_CTRL, 32'h7);
    for (int i = 0; i < 42; i++) drive_beat(64'(i), (i == 9) || (i == 25) || (i == 41), 8'hFF);
    idle(2);
    bus_read(A_ERRCNT, r);
    n_checks++; if (r !== 32'd1) begin n_fail++; $display("FAIL t3_err_cnt: got %0d want 1", r); end
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h5) begin n_fail++; $display("FAIL t3_status: got %h want 5", r); end
    bus_read(A_PKTCNT, r);
    n_checks++; if (r !== 32'd3) begin n_fail++; $display("FAIL t3_pkt_cnt: got %0d want 3", r); end
  endtask

  task automatic test_ready_mask();
    logic [31:0] r;
    logic [7:0]  mask;
    logic [63:0] nd;
    bit          acc;
    mask = 8'h55; nd = 0;
    bus_write(A_CTRL, 32'h0);
    bus_write(A_MASK, {24'd0, mask});
    bus_write(A_CTRL, 32'h7);
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL t4_clear_tready: got %b want 0", tready); end
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      tvalid = 1'b1; tdata = nd; tlast = 1'b0; tkeep = 8'hFF;
      n_checks++;
      if (tready !== mask[k % 8]) begin n_fail++; $display("FAIL t4_tready_phase%0d: got %b want %b", k % 8, tready, mask[k % 8]); end
      acc = tready;
      @(posedge clk); #1;
      if (acc) begin model_beat(nd, 1'b0, 8'hFF); nd = nd + 1; end
    end
    idle(1);
    bus_read(A_WORD, r);
    n_checks++; if (r !== 32'd8) begin n_fail++; $display("FAIL t4_word_cnt: got %0d want 8", r); end
    drive_beat(nd, 1'b0, 8'h0F);
    idle(2);
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h9) begin n_fail++; $display("FAIL t4_status_keep: got %h want 9", r); end
    bus_read(A_ERRCNT, r);
    n_checks++; if (r !== 32'd1) begin n_fail++; $display("FAIL t4_err_cnt: got %0d want 1", r); end
  endtask

  task automatic test_clear_midstream();
    logic [31:0] r;
    logic [63:0] d0;
    bus_write(A_MASK, 32'hFF);
    bus_write(A_PKT, 8);
    bus_write(A_CTRL, 32'h7);
    for (int i = 0; i < 5; i++) drive_beat(64'(i), 1'b0, 8'hFF);
    tvalid = 1'b1; tdata = 64'd5; tlast = 1'b0; tkeep = 8'hFF;
    addr = A_CTRL; wdata = 32'h7; wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
    model_clear();
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL t5_tready_on_clear: got %b want 0", tready); end
    idle(1);
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL t5_status: got %h want 0", r); end
    bus_read(A_WORD, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL t5_word_cnt: got %0d want 0", r); end
    bus_read(A_PKTCNT, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL t5_pkt_cnt: got %0d want 0", r); end
    d0 = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) drive_beat(d0 + 64'(i), i == 7, 8'hFF);
    idle(2);
    bus_read(A_ERRCNT, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL t5_lock_err_cnt: got %0d want 0", r); end
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL t5_lock_status: got %h want 1", r); end
  endtask

  task automatic test_bus();
    logic [31:0] r;
    bus_read(32'h40, r);
    n_checks++; if (ack !== 1'b1 || r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL t6_unmapped: ack %b rdata %h want 1 ffffffff", ack, r); end
    bus_write(A_PKT, 1);
    bus_read(A_PKT, r);
    n_checks++; if (r !== 32'd1) begin n_fail++; $display("FAIL t6_pkt_readback: got %h want 1", r); end
    bus_write(A_CTRL, 32'h7);
    bus_read(A_CTRL, r);
    n_checks++; if (r !== 32'h6) begin n_fail++; $display("FAIL t6_ctrl_readback: got %h want 6", r); end
    for (int i = 0; i < 6; i++) drive_beat(64'h0000_0000_FFFF_FFFD + 64'(i), (i % 2) == 1, 8'hFF);
    idle(2);
    bus_read(A_ERRCNT, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL t6_pkt2_err_cnt: got %0d want 0", r); end
    bus_read(A_PKTCNT, r);
    n_checks++; if (r !== 32'd3) begin n_fail++; $display("FAIL t6_pkt2_pkt_cnt: got %0d want 3", r); end
    bus_read(A_LO, r);
    n_checks++; if (r !== 32'h2) begin n_fail++; $display("FAIL t6_last_lo: got %h want 2", r); end
    bus_read(A_HI, r);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL t6_last_hi: got %h want 1", r); end
    n_checks++; if (sys_err !== 1'b0) begin n_fail++; $display("FAIL t6_sys_err: got %b want 0", sys_err); end
  endtask

  task automatic test_random();
    logic [31:0] r, ps;
    logic [63:0] d, ds;
    bit          l;
    logic [7:0]  k;
    for (int it = 0; it < 4; it++) begin
      ps = $urandom_range(2, 9);
      bus_write(A_PKT, ps);
      bus_write(A_MASK, {24'd0, 8'($urandom) | 8'h01});
      bus_write(A_CTRL, 32'h7);
      d = {$urandom, $urandom};
      for (int i = 0; i < 60; i++) begin
        ds = ($urandom_range(0, 15) == 0) ? d ^ (64'd1 << $urandom_range(0, 63)) : d;
        l  = ((i % ps) == ps - 1) ^ ($urandom_range(0, 15) == 0);
        k  = ($urandom_range(0, 15) == 0) ? 8'($urandom) & 8'hFE : 8'hFF;
        drive_beat(ds, l, k);
        d = d + 1;
        idle($urandom_range(0, 2));
      end
      idle(2);
      bus_read(A_WORD, r);
      n_checks++; if (r !== m_word) begin n_fail++; $display("FAIL rnd%0d_word_cnt: got %0d want %0d", it, r, m_word); end
      bus_read(A_PKTCNT, r);
      n_checks++; if (r !== m_pkt) begin n_fail++; $display("FAIL rnd%0d_pkt_cnt: got %0d want %0d", it, r, m_pkt); end
      bus_read(A_ERRCNT, r);
      n_checks++; if (r !== m_err) begin n_fail++; $display("FAIL rnd%0d_err_cnt: got %0d want %0d", it, r, m_err); end
      bus_read(A_STATUS, r);
      n_checks++; if (r !== {28'd0, m_st}) begin n_fail++; $display("FAIL rnd%0d_status: got %h want %h", it, r, m_st); end
      n_checks++; if (err !== (|m_st[3:1])) begin n_fail++; $display("FAIL rnd%0d_err_o: got %b want %b", it, err, |m_st[3:1]); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_stream();
    test_data_error();
    test_last_error();
    test_ready_mask();
    test_clear_midstream();
    test_bus();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
